// File: rtl/brq_pkg.sv
// ---------------------------------------------------------------------------
// brq_pkg
// Shared definitions for the ICCM boot loader:
//   state_e    - loader FSM states
//   WordBytes  - bytes per ICCM word (data words and checksum word)
//   LenBytes   - bytes in the word-count header (LSB first)
//   maxWords() - largest word count that fits an ICCM of the given
//                byte-address width
// ---------------------------------------------------------------------------
package brq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_WRITE,
        ST_CHK,
        ST_DONE
    } state_e;

    localparam int WordBytes = 4;
    localparam int LenBytes  = 2;

    // Largest legal word count. Any count above this would push the last
    // word address past the top of the ICCM, so the loader rejects it
    // before writing anything and the byte address can never wrap.
    function automatic logic [31:0] maxWords(input int addrWidth);
        return 32'd1 << (addrWidth - 2);
    endfunction

endpackage

// File: rtl/brq_word_pack.sv
// ---------------------------------------------------------------------------
// brq_word_pack
// Little-endian byte-to-word packer shared by the data and checksum phases.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset
//   valid_i - byte_i is being consumed this cycle
//   byte_i  - incoming byte
//   idx_i   - byte lane for byte_i (0 -> bits 7:0)
//   word_o  - assembled word, already including byte_i when valid_i=1
//   full_o  - this cycle completes the word (last lane written)
// ---------------------------------------------------------------------------
module brq_word_pack
    import brq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  idx_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [31:0] word_q;
    logic [31:0] word_d;

    // The incoming byte is merged combinationally so that the complete word
    // is available in the same cycle as its final byte.
    always_comb begin
        word_d = word_q;
        if (valid_i) begin
            word_d[{idx_i, 3'b000} +: 8] = byte_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
        end else if (valid_i) begin
            word_q <= word_d;
        end
    end

    assign word_o = word_d;
    assign full_o = valid_i && (idx_i == 2'(WordBytes - 1));

endmodule

// File: rtl/iccm_loader.sv
// ---------------------------------------------------------------------------
// iccm_loader
// Receives a boot image over a byte stream and writes it into the ICCM
// while holding the core in reset.
// Stream format: 16-bit word count N (LSB first), N little-endian words,
// then a little-endian checksum word equal to the XOR of all data words.
// Ports:
//   brq_clk, brq_rst     - clock and synchronous active-high reset
//   load_start           - one-cycle request to begin a load (IDLE only)
//   rx_valid, rx_data    - byte stream from the serial receiver
//   rx_ready             - loader accepts the byte this cycle
//   iccm_we/addr/wdata   - ICCM write port, one word per WRITE cycle
//   load_busy            - a load is in progress
//   load_done            - one-cycle pulse at the end of every load
//   load_err             - sticky error: bad length, bad checksum, timeout
//   core_hold            - keeps the core in reset during reset or a load
// ---------------------------------------------------------------------------
module iccm_loader
    import brq_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 15,
    parameter int TimeoutCycles = 1000000
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic                 load_start,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_ready,
    output logic                 iccm_we,
    output logic [AddrWidth-1:0] iccm_addr,
    output logic [DataWidth-1:0] iccm_wdata,
    output logic                 load_busy,
    output logic                 load_done,
    output logic                 load_err,
    output logic                 core_hold
);

    localparam int TimerWidth = $clog2(TimeoutCycles + 1);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

    state_e                 state_q;
    logic [15:0]            wordCount_q;
    logic [15:0]            wordIdx_q;
    logic [1:0]             byteIdx_q;
    logic [DataWidth-1:0]   checksum_q;
    logic [TimerWidth-1:0]  timer_q;
    logic [AddrWidth-1:0]   iccmAddr_q;
    logic [DataWidth-1:0]   iccmWdata_q;
    logic                   loadErr_q;

    logic        rxWaiting;
    logic        byteAccept;
    logic        packValid;
    logic [31:0] packWord;
    logic        packFull;
    logic [15:0] lenWord;

    assign rxWaiting  = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                        (state_q == ST_DATA) || (state_q == ST_CHK);
    assign byteAccept = rxWaiting && rx_valid;
    assign packValid  = byteAccept && ((state_q == ST_DATA) || (state_q == ST_CHK));
    assign lenWord    = {rx_data, wordCount_q[7:0]};

    brq_word_pack u_word_pack (
        .clk_i   (brq_clk),
        .rst_i   (brq_rst),
        .valid_i (packValid),
        .byte_i  (rx_data),
        .idx_i   (byteIdx_q),
        .word_o  (packWord),
        .full_o  (packFull)
    );

    // Loader FSM. The idle-byte timer is handled ahead of the state case:
    // it only runs while a byte is expected, and an accepted byte restarts it.
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            state_q     <= ST_IDLE;
            wordCount_q <= '0;
            wordIdx_q   <= '0;
            byteIdx_q   <= '0;
            checksum_q  <= '0;
            timer_q     <= '0;
            iccmAddr_q  <= '0;
            iccmWdata_q <= '0;
            loadErr_q   <= 1'b0;
        end else begin
            if (rxWaiting) begin
                if (byteAccept) begin
                    timer_q <= '0;
                end else if (timer_q == TimerLast) begin
                    loadErr_q <= 1'b1;
                    state_q   <= ST_DONE;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_q     <= ST_LEN0;
                        loadErr_q   <= 1'b0;
                        wordCount_q <= '0;
                        wordIdx_q   <= '0;
                        byteIdx_q   <= '0;
                        checksum_q  <= '0;
                        timer_q     <= '0;
                        iccmAddr_q  <= '0;
                    end
                end

                ST_LEN0: begin
                    if (byteAccept) begin
                        wordCount_q[7:0] <= rx_data;
                        state_q          <= ST_LEN1;
                    end
                end

                ST_LEN1: begin
                    if (byteAccept) begin
                        wordCount_q[15:8] <= rx_data;
                        if (lenWord == 16'd0) begin
                            state_q <= ST_CHK;
                        end else if ({16'd0, lenWord} > maxWords(AddrWidth)) begin
                            loadErr_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (byteAccept) begin
                        byteIdx_q <= byteIdx_q + 2'd1;
                        if (packFull) begin
                            iccmWdata_q <= DataWidth'(packWord);
                            iccmAddr_q  <= AddrWidth'({wordIdx_q, 2'b00});
                            state_q     <= ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    checksum_q <= checksum_q ^ iccmWdata_q;
                    wordIdx_q  <= wordIdx_q + 16'd1;
                    if (({1'b0, wordIdx_q} + 17'd1) < {1'b0, wordCount_q}) begin
                        state_q <= ST_DATA;
                    end else begin
                        state_q <= ST_CHK;
                    end
                end

                ST_CHK: begin
                    if (byteAccept) begin
                        byteIdx_q <= byteIdx_q + 2'd1;
                        if (packFull) begin
                            if (DataWidth'(packWord) != checksum_q) begin
                                loadErr_q <= 1'b1;
                            end
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_ready   = rxWaiting;
    assign iccm_we    = (state_q == ST_WRITE);
    assign iccm_addr  = iccmAddr_q;
    assign iccm_wdata = iccmWdata_q;
    assign load_busy  = (state_q != ST_IDLE);
    assign load_done  = (state_q == ST_DONE);
    assign load_err   = loadErr_q;
    assign core_hold  = brq_rst || load_busy;

endmodule

// File: tb/tb_iccm_loader.sv
// ---------------------------------------------------------------------------
// tb_iccm_loader
// Self-checking bench for iccm_loader (AddrWidth=15, TimeoutCycles=16).
// A cycle table covers a good two-word load and a one-word load with a bad
// checksum, an ignored load_start and an ignored byte during WRITE; hand
// sequences cover oversize length, zero length, timeout and reset mid-load.
// ---------------------------------------------------------------------------
module tb_iccm_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        loadStart = 1'b0;
    logic        rxValid = 1'b0;
    logic [7:0]  rxData = 8'h00;
    logic        rxReady;
    logic        iccmWe;
    logic [14:0] iccmAddr;
    logic [31:0] iccmWdata;
    logic        loadBusy;
    logic        loadDone;
    logic        loadErr;
    logic        coreHold;

    int checkCount = 0;
    int passCount  = 0;
    int weCount    = 0;
    int doneCount  = 0;

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        ready;
        logic        we;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    iccm_loader #(
        .DataWidth     (32),
        .AddrWidth     (15),
        .TimeoutCycles (16)
    ) dut (
        .brq_clk    (clock),
        .brq_rst    (reset),
        .load_start (loadStart),
        .rx_valid   (rxValid),
        .rx_data    (rxData),
        .rx_ready   (rxReady),
        .iccm_we    (iccmWe),
        .iccm_addr  (iccmAddr),
        .iccm_wdata (iccmWdata),
        .load_busy  (loadBusy),
        .load_done  (loadDone),
        .load_err   (loadErr),
        .core_hold  (coreHold)
    );

    always #5 clock = ~clock;

    // Count write strobes and done pulses mid-cycle, away from the edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (iccmWe) weCount++;
            if (loadDone) doneCount++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic start, input logic valid, input logic [7:0] data);
        @(negedge clock);
        loadStart = start;
        rxValid   = valid;
        rxData    = data;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic logic [63:0] outVec();
        return {11'd0, rxReady, iccmWe, iccmAddr, iccmWdata, loadBusy, loadDone, loadErr, coreHold};
    endfunction

    function automatic logic [63:0] expVec(input vec_t v);
        return {11'd0, v.ready, v.we, v.addr, v.wdata, v.busy, v.done, v.err, v.busy};
    endfunction

    task automatic sendBytes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        applyStimulus(1'b0, 1'b1, b0);
        applyStimulus(1'b0, 1'b1, b1);
        applyStimulus(1'b0, 1'b1, b2);
        applyStimulus(1'b0, 1'b1, b3);
    endtask

    initial begin
        int weBase;
        int doneBase;
        int waited;
        logic found;

        // Two-word load with a correct checksum.
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 15'h0000, 32'h00000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 15'h0000, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 15'h0000, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 15'h0000, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 15'h0000, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 15'h0000, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 15'h0000, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 15'h0000, 32'h00000013, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hEF, 1'b1, 1'b0, 15'h0000, 32'h00000013, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hBE, 1'b1, 1'b0, 15'h0000, 32'h00000013, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hAD, 1'b1, 1'b0, 15'h0000, 32'h00000013, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hDE, 1'b1, 1'b0, 15'h0000, 32'h00000013, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 15'h0004, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hFC, 1'b1, 1'b0, 15'h0004, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hBE, 1'b1, 1'b0, 15'h0004, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hAD, 1'b1, 1'b0, 15'h0004, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hDE, 1'b1, 1'b0, 15'h0004, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 15'h0004, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 15'h0004, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0});
        // One-word load, bad checksum, stray load_start in DATA, byte offered in WRITE.
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 15'h0004, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 15'h0000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 15'h0000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'h78, 1'b1, 1'b0, 15'h0000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h56, 1'b1, 1'b0, 15'h0000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 15'h0000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 15'h0000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 15'h0000, 32'h12345678, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 15'h0000, 32'h12345678, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 15'h0000, 32'h12345678, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 15'h0000, 32'h12345678, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 15'h0000, 32'h12345678, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 15'h0000, 32'h12345678, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 15'h0000, 32'h12345678, 1'b0, 1'b0, 1'b1});

        // Reset state: everything low except core_hold.
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        checkOutput("reset_state", outVec(), 64'h1);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].start, vecs[i].valid, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), outVec(), expVec(vecs[i]));
        end
        checkOutput("table_we_count", 64'(weCount), 64'd3);
        checkOutput("table_done_count", 64'(doneCount), 64'd2);

        // Oversize length 0x2001: abort right after the second length byte.
        weBase = weCount;
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("big_err_sticky_in_idle", 64'(loadErr), 64'd1);
        applyStimulus(1'b0, 1'b1, 8'h01);
        checkOutput("big_err_cleared", 64'(loadErr), 64'd0);
        applyStimulus(1'b0, 1'b1, 8'h20);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("big_done_err", {62'd0, loadDone, loadErr}, 64'd3);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("big_idle", {62'd0, loadBusy, loadDone}, 64'd0);
        checkOutput("big_no_write", 64'(weCount - weBase), 64'd0);

        // Zero length: straight to the checksum, which must be zero.
        weBase = weCount;
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00);
        sendBytes(8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("zero_done_ok", {62'd0, loadDone, loadErr}, 64'd2);
        checkOutput("zero_no_write", 64'(weCount - weBase), 64'd0);

        // Timeout: two data bytes, then the stream stalls.
        weBase   = weCount;
        doneBase = doneCount;
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h11);
        applyStimulus(1'b0, 1'b1, 8'h22);
        found  = 1'b0;
        waited = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            if (loadDone) begin
                found  = 1'b1;
                waited = i;
            end
        end
        checkOutput("timeout_done_seen", 64'(found), 64'd1);
        checkOutput("timeout_latency_in_range", 64'(waited >= 15 && waited <= 18), 64'd1);
        checkOutput("timeout_err", 64'(loadErr), 64'd1);
        checkOutput("timeout_no_write", 64'(weCount - weBase), 64'd0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("timeout_done_once", 64'(doneCount - doneBase), 64'd1);

        // Reset after the first WRITE of a four-word load.
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h04);
        applyStimulus(1'b0, 1'b1, 8'h00);
        sendBytes(8'h01, 8'h02, 8'h03, 8'h04);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("rst_first_write", {31'd0, iccmWe, iccmAddr, iccmWdata}, {31'd0, 1'b1, 15'h0000, 32'h04030201});
        @(negedge clock);
        reset   = 1'b1;
        rxValid = 1'b1;
        rxData  = 8'h55;
        #1;
        checkOutput("rst_core_hold", 64'(coreHold), 64'd1);
        @(negedge clock);
        reset   = 1'b0;
        rxValid = 1'b0;
        #1;
        checkOutput("rst_outputs_cleared", outVec(), 64'h0);
        weBase = weCount;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'hA0 + i));
        end
        checkOutput("rst_no_write_after", 64'(weCount - weBase), 64'd0);
        checkOutput("rst_stays_idle", {62'd0, loadBusy, rxReady}, 64'd0);

        // Fresh one-word load after the reset starts again at address 0.
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'h00);
        sendBytes(8'h0D, 8'hF0, 8'hFE, 8'hCA);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("reload_write", {31'd0, iccmWe, iccmAddr, iccmWdata}, {31'd0, 1'b1, 15'h0000, 32'hCAFEF00D});
        sendBytes(8'h0D, 8'hF0, 8'hFE, 8'hCA);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("reload_done_ok", {62'd0, loadDone, loadErr}, 64'd2);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("reload_core_released", 64'(coreHold), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
